// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 64-bit adder/subtractor.
// A round-robin req/gnt arbiter latches the winning operands. The adder
// runs for one cycle, and the result and Y86 flags come back registered.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             last_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_id;

  logic             elig0_c;
  logic             elig1_c;
  logic             win_valid_c;
  logic             win_id_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [EW-1:0]    sum_c;
  logic             c_msb_in_c;

  // Eligibility, round-robin winner and next state
  always_comb begin
    state_next  = state;
    elig0_c     = req0 & ~gnt0;
    elig1_c     = req1 & ~gnt1;
    win_valid_c = elig0_c | elig1_c;
    // Both eligible: take the port not granted last; otherwise the lone one
    win_id_c    = (elig0_c & elig1_c) ? ~last_id : elig1_c;
    case (state)
      S_IDLE:  if (win_valid_c) state_next = S_BUSY;
      S_BUSY:  state_next = win_valid_c ? S_BUSY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Shared adder on latched operands; subtract is a + ~b + 1
  always_comb begin
    b_eff_c    = op_sub ? ~op_b : op_b;
    sum_c      = EW'(op_a) + EW'(b_eff_c) + EW'(op_sub);
    // Carry into the MSB is recovered from the MSB sum bit
    c_msb_in_c = sum_c[WIDTH-1] ^ op_a[WIDTH-1] ^ b_eff_c[WIDTH-1];
  end

  assign busy = (state == S_BUSY);

  // State, grant, operand latch and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      last_id <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      of      <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_sub  <= 1'b0;
      op_id   <= 1'b0;
    end else begin
      state <= state_next;
      gnt0  <= win_valid_c & ~win_id_c;
      gnt1  <= win_valid_c & win_id_c;
      done  <= (state == S_BUSY);
      if (win_valid_c) begin
        last_id <= win_id_c;
        op_id   <= win_id_c;
        op_a    <= win_id_c ? a1 : a0;
        op_b    <= win_id_c ? b1 : b0;
        op_sub  <= win_id_c ? sub1 : sub0;
      end
      if (state == S_BUSY) begin
        done_id <= op_id;
        result  <= sum_c[WIDTH-1:0];
        carry   <= sum_c[WIDTH];
        zf      <= (sum_c[WIDTH-1:0] == '0);
        sf      <= sum_c[WIDTH-1];
        of      <= c_msb_in_c ^ sum_c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: per-port expected-result queues filled at request
// time, drained by a monitor on every done strobe.
`timescale 1ns/1ps
module tb_addsub_arbiter;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id;
  logic [W-1:0] result;
  logic         carry, zf, sf, of;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         s;
    logic         o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   gnt_cyc[$];
  int   gnt_id[$];
  int   done_cyc[$];
  int   done_idq[$];
  exp_t mon_e;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .carry(carry), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: plain two's-complement arithmetic and sign rules
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W:0] w;
    w = '0;
    if (s) begin
      e.r = a - b;
      e.c = (a >= b);
      e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    end else begin
      w   = {1'b0, a} + {1'b0, b};
      e.r = w[W-1:0];
      e.c = w[W];
      e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    end
    e.z = (e.r == '0);
    e.s = e.r[W-1];
    return e;
  endfunction

  // Monitor: one-hot grants, log events, score every done
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", W'(gnt0 & gnt1), '0);
        gnt_cyc.push_back(cyc);
        gnt_id.push_back(int'(gnt1));
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_idq.push_back(int'(done_id));
        if ((done_id == 1'b0 && q0.size() == 0) || (done_id == 1'b1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done_id%0d required=no_done", done_id);
        end else begin
          mon_e = done_id ? q1.pop_front() : q0.pop_front();
          chk("result", result, mon_e.r);
          chk("flags_c_z_s_o", W'({carry, zf, sf, of}), W'({mon_e.c, mon_e.z, mon_e.s, mon_e.o}));
        end
      end
    end
  end

  // One requester transaction; returns in the done cycle after gnt drops
  task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit drop, input int want_wait);
    int waits;
    bit got;
    waits = 0;
    got   = 1'b0;
    if (p == 0) begin
      a0 = a; b0 = b; sub0 = s; req0 = 1'b1; q0.push_back(model(a, b, s));
    end else begin
      a1 = a; b1 = b; sub1 = s; req1 = 1'b1; q1.push_back(model(a, b, s));
    end
    while (!got && waits < 20) begin
      @(posedge clk); #1;
      waits++;
      got = (p == 0) ? gnt0 : gnt1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout port%0d actual=none required=gnt", p);
    end else if (want_wait > 0) begin
      chk("grant_latency", W'(waits), W'(want_wait));
    end
    @(posedge clk); #1;
    if (want_wait > 0) chk("done_latency", W'(done), W'(1));
    if (drop) begin
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      1:       v = 64'h8000_0000_0000_0000;
      2:       v = W'($urandom_range(0, 3));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic run_rand(input int p, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      a = rand_val();
      b = ($urandom_range(0, 3) == 0) ? a : rand_val();
      s = 1'($urandom_range(0, 1));
      do_op(p, a, b, s, gaps || (i == n - 1), 0);
      if (gaps) begin
        int k;
        k = $urandom_range(0, 2);
        repeat (k) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic settle_and_clear();
    repeat (3) begin @(posedge clk); #1; end
    gnt_cyc.delete(); gnt_id.delete(); done_cyc.delete(); done_idq.delete();
  endtask

  initial begin
    int waits;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("gnt_during_reset", W'({gnt0, gnt1}), '0);
    chk("reset_outputs", W'({gnt0, gnt1, busy, done, done_id, carry, zf, sf, of}), '0);
    chk("reset_result", result, '0);
    req0 = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;

    // Reset during the BUSY cycle of a granted op
    a0 = 64'd3; b0 = 64'd4; req0 = 1'b1;
    waits = 0;
    while (!gnt0 && waits < 10) begin @(posedge clk); #1; waits++; end
    chk("prereset_grant", W'(gnt0), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midop_reset_outputs", W'({gnt0, gnt1, busy, done, done_id, carry, zf, sf, of}), '0);
    chk("midop_reset_result", result, '0);
    req0 = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;
    chk("no_done_after_reset", W'(done), '0);
    gnt_id.delete();
    fork
      do_op(0, 64'd1, 64'd2, 1'b0, 1'b1, 0);
      do_op(1, 64'd9, 64'd4, 1'b1, 1'b1, 0);
    join
    if (gnt_id.size() == 0) begin
      checks++; errors++;
      $display("FAIL post_reset_first_gnt actual=none required=port0");
    end else chk("post_reset_first_gnt", W'(gnt_id[0]), '0);
    settle_and_clear();

    // Directed arithmetic cases; end on port 1 so port 0 wins next contention
    do_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 1);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1);
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1);
    do_op(1, 64'h10, 64'h10, 1'b1, 1'b1, 1);
    do_op(1, 64'd0, 64'd1, 1'b1, 1'b1, 1);
    settle_and_clear();

    // Contention: both held, 6 ops each
    fork
      run_rand(0, 6, 1'b0);
      run_rand(1, 6, 1'b0);
    join
    settle_and_clear_check_contention();

    // Single-port streaming
    run_rand(0, 5, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("stream_gnt_count", W'(gnt_id.size()), W'(5));
    for (int i = 0; i < gnt_id.size(); i++) begin
      chk("stream_gnt_port", W'(gnt_id[i]), '0);
      if (i > 0) chk("stream_gnt_spacing", W'(gnt_cyc[i] - gnt_cyc[i-1]), W'(2));
    end
    for (int i = 0; i < done_idq.size(); i++) chk("stream_done_id", W'(done_idq[i]), '0);
    settle_and_clear();

    // Mixed random traffic with idle gaps
    fork
      run_rand(0, 25, 1'b1);
      run_rand(1, 25, 1'b1);
    join
    repeat (4) begin @(posedge clk); #1; end
    chk("queue0_drained", W'(q0.size()), '0);
    chk("queue1_drained", W'(q1.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic settle_and_clear_check_contention();
    repeat (3) begin @(posedge clk); #1; end
    chk("contention_gnt_count", W'(gnt_id.size()), W'(12));
    chk("contention_done_count", W'(done_idq.size()), W'(12));
    for (int i = 0; i < gnt_id.size(); i++) begin
      chk("contention_gnt_order", W'(gnt_id[i]), W'(i % 2));
      if (i > 0) chk("contention_gnt_spacing", W'(gnt_cyc[i] - gnt_cyc[i-1]), W'(1));
    end
    for (int i = 0; i < done_idq.size(); i++) begin
      chk("contention_done_id", W'(done_idq[i]), W'(i % 2));
      if (i > 0) chk("contention_done_spacing", W'(done_cyc[i] - done_cyc[i-1]), W'(1));
    end
    gnt_cyc.delete(); gnt_id.delete(); done_cyc.delete(); done_idq.delete();
  endtask

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares a single 64-bit ripple-carry adder/subtractor between two requesters (port 0: execute-stage ALU; port 1: PC/stack-pointer update unit) in the Y86 datapath. A round-robin arbiter with a req/gnt handshake latches the winning operands, drives the shared adder for one cycle, and returns a registered result with carry and Y86 condition flags (ZF, SF, OF) tagged by requester.

## Interface
- Parameters:
- WIDTH, 64, operand/result width; the shared adder is fixed at 64 and no other value is supported.
- Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1.
- sub0 / sub1  in  1  operation select: 0 = a+b, 1 = a−b.
- a0, b0 / a1, b1  in  64 each  operands for port 0 / port 1.
- gnt0 / gnt1  out  1  one-cycle grant; operands captured at the edge that raises it.
- busy  out  1  high while an operation occupies the adder.
- done  out  1  one-cycle result-valid strobe.
- done_id  out  1  requester the result belongs to (0 or 1).
- result  out  64  registered sum/difference.
- carry  out  1  carry out of bit 63 (subtract: 1 = no borrow).
- zf, sf, of  out  1 each  result==0, result[63], signed overflow.

## Operation
- Shared adder: sub=1 inverts b and injects cin=1, giving result = a + ~b + 1. of = carry into bit 63 XOR carry out of bit 63. Operand order is the requester's responsibility (Y86 subq supplies a=valB, b=valA).
- FSM states:
- IDLE: no operation latched.
- BUSY: latched operands feed the adder.
- Eligibility at an edge: reqN high and gntN not high in the current cycle.
- IDLE → BUSY: at an edge where any requester is eligible.
  - Pick the winner and latch its a, b, sub and id.
  - Assert gnt of the winner only in the next cycle.
  - Update the round-robin pointer to the winner.
- BUSY exit: at the next edge, register result, carry, zf, sf, of and done_id, and pulse done. Then:
  - If any requester is eligible, grant it at that same edge and stay in BUSY (back-to-back).
  - Otherwise go to IDLE.
- Round robin:
  - If both are eligible, grant the port not granted last.
  - After reset the pointer favours port 0 first.
  - A single eligible requester always wins.
- Requester rules:
  - Hold req, sub, a and b stable from req rise until gnt is seen.
  - Drop req at the edge ending the gnt cycle unless another operation is wanted.
  - A held req is re-granted no sooner than 2 cycles after the previous grant.
- result/flags hold their last value until the next done; they are valid only in the done cycle by contract.
- busy = (state == BUSY).

## Timing
- Latency: req sampled at edge E1 → gnt in cycle after E1 → done, result and flags in cycle after E2 (2 edges from req sample).
- Throughput:
  - 1 op/cycle when the two ports alternate.
  - 1 op per 2 cycles for a single continuously requesting port.
- gnt0 and gnt1 are never high together; done and the next gnt may be high in the same cycle.
- Reset (any cycle, including mid-operation):
  - Next cycle all outputs are 0: gnt0, gnt1, busy, done, done_id, result, carry, zf, sf, of.
  - State is IDLE and the pointer favours port 0.
  - A latched operation is discarded with no done.
- req asserted during reset is ignored; it is first sampled at the first edge with rst low.
- No combinational path from req/a/b to any output.

## Test plan
- Reset mid-op:
  - Stimulus: rst during the BUSY cycle of a granted op.
  - Required: no done follows; all outputs 0 next cycle.
  - Required: the first req afterwards from both ports is granted to port 0.
- Single add:
  - Stimulus: req0, a0=5, b0=7, sub0=0.
  - Required: gnt0 one cycle later; done one cycle after that with result=12, done_id=0, zf=0, sf=0, of=0, carry=0.
- Subtract to zero and borrow:
  - Stimulus: req1, a1=b1=0x10, sub1=1.
  - Required: result=0, zf=1, carry=1, done_id=1.
  - Stimulus: then a1=0, b1=1.
  - Required: result=0xFFFF_FFFF_FFFF_FFFF, sf=1, carry=0.
- Signed overflow:
  - Stimulus: a0=0x7FFF_FFFF_FFFF_FFFF, b0=1, add.
  - Required: result=0x8000_0000_0000_0000, of=1, sf=1, carry=0.
  - Stimulus: a0=0x8000_0000_0000_0000, b0=1, subtract.
  - Required: result=0x7FFF_FFFF_FFFF_FFFF, of=1.
- Contention:
  - Stimulus: req0 and req1 held high continuously, 6 ops each.
  - Required: grants alternate 0,1,0,1…, starting with 0; one done per cycle after the first.
  - Required: done_id alternates, and every result matches its port's operands.
- Single-port streaming:
  - Stimulus: req0 held high for 10 cycles.
  - Required: gnt0 every other cycle, never two consecutive cycles.
  - Required: gnt1 stays 0, and every done has done_id=0.
